// File: rtl/branch_resolve_predictor.sv
// Fetch-time branch prediction (2-bit PHT + direct-mapped BTB) and
// EX-stage resolution from the ALU Zero flag with registered redirect.
module branch_resolve_predictor #(
  parameter int         PHT_BITS = 6,
  parameter int         BTB_BITS = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_branch_ne,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        alu_zero,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam int TAG_W = 30 - BTB_BITS;

  logic [1:0]       pht_q [PHT_N];
  logic             btb_v_q [BTB_N];
  logic [TAG_W-1:0] btb_tag_q [BTB_N];
  logic [31:0]      btb_tgt_q [BTB_N];

  logic        mispredict_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  logic [PHT_BITS-1:0] f_pht_idx;
  logic [BTB_BITS-1:0] f_btb_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                f_hit;

  logic [PHT_BITS-1:0] e_pht_idx;
  logic [BTB_BITS-1:0] e_btb_idx;
  logic [TAG_W-1:0]    e_tag;

  logic        resolve;
  logic        taken;
  logic        mp_cond;
  logic [31:0] next_pc;
  logic [1:0]  cnt_d;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^{fetch_pc[1:0], ex_pc[1:0]};

  assign f_pht_idx = fetch_pc[PHT_BITS+1:2];
  assign f_btb_idx = fetch_pc[BTB_BITS+1:2];
  assign f_tag     = fetch_pc[31:BTB_BITS+2];
  assign f_hit     = btb_v_q[f_btb_idx]
                  && (btb_tag_q[f_btb_idx] == f_tag);

  // Reads come straight from state, so a same-edge update is not forwarded
  assign pred_taken  = f_hit && pht_q[f_pht_idx][1];
  assign pred_target = pred_taken ? btb_tgt_q[f_btb_idx]
                                  : fetch_pc + 32'd4;

  assign e_pht_idx = ex_pc[PHT_BITS+1:2];
  assign e_btb_idx = ex_pc[BTB_BITS+1:2];
  assign e_tag     = ex_pc[31:BTB_BITS+2];

  assign resolve = ex_valid && ex_is_branch;
  assign taken   = alu_zero ^ ex_branch_ne;
  assign next_pc = taken ? ex_target : ex_pc + 32'd4;
  assign mp_cond = (taken != ex_pred_taken)
                || (taken && (ex_pred_target != ex_target));

  always_comb begin
    cnt_d = pht_q[e_pht_idx];
    if (taken && cnt_d != 2'b11) begin
      cnt_d = cnt_d + 2'd1;
    end else if (!taken && cnt_d != 2'b00) begin
      cnt_d = cnt_d - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_INIT;
      for (int i = 0; i < BTB_N; i++) btb_v_q[i] <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= resolve && mp_cond;
      if (resolve) begin
        pht_q[e_pht_idx] <= cnt_d;
        redirect_pc_q    <= next_pc;
        if (taken) btb_v_q[e_btb_idx] <= 1'b1;
        if (branch_cnt_q != '1) begin
          branch_cnt_q <= branch_cnt_q + 32'd1;
        end
        if (mp_cond && mispred_cnt_q != '1) begin
          mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
      end
    end
  end

  // Tag/target payload is qualified by the valid bit and needs no reset
  always_ff @(posedge clk) begin
    if (resolve && taken) begin
      btb_tag_q[e_btb_idx] <= e_tag;
      btb_tgt_q[e_btb_idx] <= ex_target;
    end
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_cnt_q;
  assign mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Randomized and directed bench for branch_resolve_predictor against
// an array-based model of the predictor tables and resolve rules.
module tb_branch_resolve_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_branch_ne = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        alu_zero = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int tests = 0;
  int failures = 0;

  int          m_pht [64];
  bit          m_bv [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  longint      m_bc;
  longint      m_mc;
  bit          m_mp;
  logic [31:0] m_red;

  always #5 clk = ~clk;

  branch_resolve_predictor dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_pc(fetch_pc),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .ex_valid(ex_valid),
    .ex_is_branch(ex_is_branch),
    .ex_branch_ne(ex_branch_ne),
    .ex_pc(ex_pc),
    .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .alu_zero(alu_zero),
    .mispredict(mispredict),
    .redirect_pc(redirect_pc),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
    m_bc = 0;
    m_mc = 0;
    m_mp = 1'b0;
    m_red = '0;
  endfunction

  function automatic void m_pred(input logic [31:0] pc,
                                 output bit pt,
                                 output logic [31:0] ptg);
    int pi;
    int bi;
    pi = int'((pc >> 2) % 64);
    bi = int'((pc >> 2) % 16);
    pt = m_bv[bi] && (m_tag[bi] == (pc >> 6)) && (m_pht[pi] >= 2);
    ptg = pt ? m_tgt[bi] : pc + 32'd4;
  endfunction

  function automatic void m_resolve(input bit v, br, ne, z,
                                    input logic [31:0] pc, tgt,
                                    input bit pt,
                                    input logic [31:0] ptg);
    bit tk;
    bit bad;
    int pi;
    int bi;
    if (!(v && br)) begin
      m_mp = 1'b0;
      return;
    end
    tk = (z != ne);
    bad = (tk != pt) || (tk && ptg != tgt);
    m_mp = bad;
    m_red = tk ? tgt : pc + 32'd4;
    if (m_bc < 64'hFFFF_FFFF) m_bc++;
    if (bad && m_mc < 64'hFFFF_FFFF) m_mc++;
    pi = int'((pc >> 2) % 64);
    bi = int'((pc >> 2) % 16);
    if (tk) m_pht[pi] = (m_pht[pi] < 3) ? m_pht[pi] + 1 : 3;
    else    m_pht[pi] = (m_pht[pi] > 0) ? m_pht[pi] - 1 : 0;
    if (tk) begin
      m_bv[bi] = 1'b1;
      m_tag[bi] = pc >> 6;
      m_tgt[bi] = tgt;
    end
  endfunction

  // One clock: drive, sample fetch prediction mid-cycle, then edge.
  task automatic step(input bit v, br, ne, z,
                      input logic [31:0] pc, tgt,
                      input bit pt,
                      input logic [31:0] ptg, fpc,
                      output bit gpt,
                      output logic [31:0] gptg,
                      output bit ept,
                      output logic [31:0] eptg);
    @(negedge clk);
    ex_valid = v;
    ex_is_branch = br;
    ex_branch_ne = ne;
    alu_zero = z;
    ex_pc = pc;
    ex_target = tgt;
    ex_pred_taken = pt;
    ex_pred_target = ptg;
    fetch_pc = fpc;
    #1;
    gpt = pred_taken;
    gptg = pred_target;
    m_pred(fpc, ept, eptg);
    @(posedge clk);
    m_resolve(v, br, ne, z, pc, tgt, pt, ptg);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_pc = 32'h40;
    #1;
    tests++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      failures++;
      $display("FAIL reset_pred: got %b/%h want 0/00000044",
               pred_taken, pred_target);
    end
    tests++;
    if (branch_count !== 0 || mispredict_count !== 0
        || mispredict !== 1'b0 || redirect_pc !== 0) begin
      failures++;
      $display("FAIL reset_regs: got bc=%0d mc=%0d mp=%b rd=%h want 0",
               branch_count, mispredict_count, mispredict, redirect_pc);
    end
  endtask

  task automatic test_first_taken();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    step(1, 1, 0, 1, 32'h40, 32'h80, 0, 32'h44, 32'h40,
         gpt, gtg, ept, etg);
    tests++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80
        || branch_count !== 1 || mispredict_count !== 1) begin
      failures++;
      $display("FAIL first_taken: got mp=%b rd=%h bc=%0d mc=%0d want 1/80/1/1",
               mispredict, redirect_pc, branch_count, mispredict_count);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, gpt, gtg, ept, etg);
    tests++;
    if (gpt !== 1'b1 || gtg !== 32'h80 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL first_taken_fetch: got %b/%h mp=%b want 1/00000080 mp=0",
               gpt, gtg, mispredict);
    end
  endtask

  task automatic test_saturate();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    for (int i = 0; i < 4; i++) begin
      m_pred(32'h40, ept, etg);
      step(1, 1, 0, 1, 32'h40, 32'h80, ept, etg, 32'h40,
           gpt, gtg, ept, etg);
      tests++;
      if (mispredict !== m_mp || branch_count !== m_bc[31:0]) begin
        failures++;
        $display("FAIL sat_taken%0d: got mp=%b bc=%0d want %b/%0d",
                 i, mispredict, branch_count, m_mp, m_bc);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80, 32'h40,
           gpt, gtg, ept, etg);
      tests++;
      if (mispredict !== 1'b1 || redirect_pc !== 32'h44) begin
        failures++;
        $display("FAIL sat_nt%0d: got mp=%b rd=%h want 1/00000044",
                 i, mispredict, redirect_pc);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, gpt, gtg, ept, etg);
    tests++;
    if (gpt !== 1'b0 || gtg !== 32'h44) begin
      failures++;
      $display("FAIL sat_fetch: got %b/%h want 0/00000044", gpt, gtg);
    end
  endtask

  task automatic test_bne_target();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    longint mc0;
    mc0 = m_mc;
    step(1, 1, 1, 0, 32'h100, 32'h200, 1, 32'h200, 32'h0,
         gpt, gtg, ept, etg);
    tests++;
    if (mispredict !== 1'b0 || branch_count !== m_bc[31:0]
        || mispredict_count !== mc0[31:0]) begin
      failures++;
      $display("FAIL bne_ok: got mp=%b bc=%0d mc=%0d want 0/%0d/%0d",
               mispredict, branch_count, mispredict_count, m_bc, mc0);
    end
    step(1, 1, 1, 0, 32'h100, 32'h200, 1, 32'h204, 32'h0,
         gpt, gtg, ept, etg);
    tests++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h200
        || mispredict_count !== mc0[31:0] + 1) begin
      failures++;
      $display("FAIL bne_target: got mp=%b rd=%h mc=%0d want 1/00000200/%0d",
               mispredict, redirect_pc, mispredict_count, mc0 + 1);
    end
  endtask

  task automatic test_alias_race();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    step(1, 1, 0, 1, 32'h40, 32'h80, 0, 32'h44, 32'h0,
         gpt, gtg, ept, etg);
    step(1, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80, 32'h0,
         gpt, gtg, ept, etg);
    step(1, 1, 0, 1, 32'h40, 32'h80, 0, 32'h44, 32'h40,
         gpt, gtg, ept, etg);
    tests++;
    if (gpt !== 1'b0 || gtg !== 32'h44) begin
      failures++;
      $display("FAIL race_old: got %b/%h want 0/00000044", gpt, gtg);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, gpt, gtg, ept, etg);
    tests++;
    if (gpt !== 1'b1 || gtg !== 32'h80) begin
      failures++;
      $display("FAIL race_new: got %b/%h want 1/00000080", gpt, gtg);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h140, gpt, gtg, ept, etg);
    tests++;
    if (gpt !== 1'b0 || gtg !== 32'h144) begin
      failures++;
      $display("FAIL alias: got %b/%h want 0/00000144", gpt, gtg);
    end
  endtask

  task automatic test_wrap();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    step(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 32'h0,
         gpt, gtg, ept, etg);
    tests++;
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap: got mp=%b rd=%h want 1/00000000",
               mispredict, redirect_pc);
    end
  endtask

  task automatic test_back_to_back();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    logic [31:0] pcs [6];
    logic [31:0] pc, tgt, fpc;
    bit v, br, ne, z, pt;
    logic [31:0] ptg;
    pcs = '{32'h40, 32'h140, 32'h100, 32'h80, 32'h1C, 32'hFFFF_FFFC};
    for (int i = 0; i < 400; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFC)
                                       : pcs[$urandom_range(0, 5)];
      tgt = ($urandom_range(0, 1) == 1) ? pc + 32'h40
                                        : {$urandom_range(0, 255), 2'b00};
      fpc = pcs[$urandom_range(0, 5)];
      v = ($urandom_range(0, 9) < 8);
      br = ($urandom_range(0, 9) < 8);
      ne = $urandom_range(0, 1);
      z = $urandom_range(0, 1);
      m_pred(pc, pt, ptg);
      if ($urandom_range(0, 3) == 0) pt = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) ptg = tgt + 32'h4;
      step(v, br, ne, z, pc, tgt, pt, ptg, fpc, gpt, gtg, ept, etg);
      tests++;
      if (gpt !== ept || gtg !== etg) begin
        failures++;
        $display("FAIL rnd_fetch[%0d]: pc=%h got %b/%h want %b/%h",
                 i, fpc, gpt, gtg, ept, etg);
      end
      tests++;
      if (mispredict !== m_mp || redirect_pc !== m_red
          || branch_count !== m_bc[31:0]
          || mispredict_count !== m_mc[31:0]) begin
        failures++;
        $display("FAIL rnd_res[%0d]: got %b/%h/%0d/%0d want %b/%h/%0d/%0d",
                 i, mispredict, redirect_pc, branch_count,
                 mispredict_count, m_mp, m_red, m_bc, m_mc);
      end
    end
  endtask

  task automatic test_async_reset();
    bit gpt, ept;
    logic [31:0] gtg, etg;
    step(1, 1, 0, 1, 32'h40, 32'h300, 0, 32'h44, 32'h0,
         gpt, gtg, ept, etg);
    tests++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: got mp=%b want 1", mispredict);
    end
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    tests++;
    if (mispredict !== 1'b0 || redirect_pc !== 0
        || branch_count !== 0 || mispredict_count !== 0) begin
      failures++;
      $display("FAIL arst: got mp=%b rd=%h bc=%0d mc=%0d want 0",
               mispredict, redirect_pc, branch_count, mispredict_count);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fetch_pc = 32'h40;
    #1;
    tests++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      failures++;
      $display("FAIL arst_fetch: got %b/%h want 0/00000044",
               pred_taken, pred_target);
    end
  endtask

  initial begin
    test_reset();
    test_first_taken();
    test_saturate();
    test_bne_target();
    test_alias_race();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predictor.md
Name: branch_resolve_predictor

Overview:
Consumer of the ALU Zero flag. Predicts branch direction and target at fetch using a 2-bit saturating-counter pattern history table (PHT) and a direct-mapped branch target buffer (BTB). Resolves branches in EX from the ALU Zero flag (BEQ/BNE compare via subtract), updates the predictor state, and issues a registered redirect on misprediction. Sits between the fetch stage and the EX stage and drives the pipeline flush/redirect path.

Parameters:
PHT_BITS, 6, log2 of PHT entries; index = pc[PHT_BITS+1:2]
BTB_BITS, 4, log2 of BTB entries; index = pc[BTB_BITS+1:2], tag = pc[31:BTB_BITS+2]
CNT_INIT, 2'b01, counter value at reset (weakly not-taken)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
fetch_pc  in  32  PC being fetched
pred_taken  out  1  combinational prediction for fetch_pc
pred_target  out  32  predicted next PC: BTB target if pred_taken, else fetch_pc+4
ex_valid  in  1  EX-stage instruction valid
ex_is_branch  in  1  EX instruction is a conditional branch
ex_branch_ne  in  1  1 = BNE (taken when Zero=0), 0 = BEQ (taken when Zero=1)
ex_pc  in  32  PC of the EX branch
ex_target  in  32  computed branch target
ex_pred_taken  in  1  prediction carried down the pipe with this branch
ex_pred_target  in  32  predicted next PC carried down the pipe
alu_zero  in  1  ALU Zero flag for the EX instruction
mispredict  out  1  registered one-cycle pulse: flush younger instructions
redirect_pc  out  32  registered correct next PC; valid while mispredict=1
branch_count  out  32  resolved branches, saturating at 0xFFFFFFFF
mispredict_count  out  32  mispredictions, saturating at 0xFFFFFFFF

Behaviour:
- Reset (rst_n=0, asynchronous): all PHT counters set to CNT_INIT; all BTB valid bits cleared; mispredict=0; redirect_pc=0; both count outputs=0. Reset during a pending mispredict takes effect immediately.
- Fetch (combinational): btb_hit = valid[idx] && tag match. pred_taken = btb_hit && PHT[idx][1].
- Fetch/update race: the read returns the pre-update counter value and BTB entry when an update to the same index lands on the same edge.
- A resolve event occurs when ex_valid && ex_is_branch. Otherwise no state changes, mispredict=0 on the next edge, and redirect_pc holds its value.
- Actual direction: taken = alu_zero XOR ex_branch_ne.
- Actual next PC: taken ? ex_target : ex_pc+4, using 32-bit wrap-around arithmetic.
- Mispredict condition: (taken != ex_pred_taken) || (taken && ex_pred_target != ex_target).
- On the edge after a resolve event: mispredict = mispredict condition; redirect_pc = actual next PC. Latency is 1 cycle.
- mispredict is a pulse. Back-to-back resolve events produce back-to-back pulses.
- PHT update on a resolve event: taken → counter+1, saturating at 2'b11; not taken → counter−1, saturating at 2'b00. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- BTB update: on a taken resolve, write valid=1, the tag, and ex_target at index(ex_pc), overwriting any entry. A not-taken resolve leaves the BTB unchanged.
- Counters: branch_count increments on each resolve event. mispredict_count increments when the mispredict condition is true. Both saturate and never wrap.
- No handshake back-pressure. The block accepts one resolve per cycle and one fetch lookup per cycle.

Test Plan:
1. Reset, then fetch_pc=0x40 → pred_taken=0, pred_target=0x44; both counts=0.
2. Resolve BEQ: ex_pc=0x40, ex_target=0x80, alu_zero=1, ex_pred_taken=0 → next cycle mispredict=1, redirect_pc=0x80, counts=1/1. Then fetch 0x40 → pred_taken=1, pred_target=0x80.
3. Four further taken resolves at 0x40 saturate its counter at 11. Two not-taken resolves (alu_zero=0) → counter 01. Fetch 0x40 → pred_taken=0. The second resolve (pred_taken=1) → mispredict, redirect_pc=0x44.
4. BNE at 0x100 with alu_zero=0 and ex_pred_taken=1, ex_pred_target=ex_target=0x200 → taken, correctly predicted; mispredict=0; only branch_count increments. Variant with ex_pred_target=0x204 → mispredict, redirect_pc=0x200.
5. Alias check: train 0x40 taken, then fetch 0x140. Both share PHT idx 16 and BTB idx 0, with different tags → pred_taken=0. Fetch and resolve the same index on the same edge → fetch sees the old counter.
6. Assert rst_n=0 mid-cycle while mispredict=1 → mispredict, redirect_pc and counts go to 0 immediately. Fetch 0x40 → pred_taken=0.
